router_ctrl: RTL and testbench
==============================

ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 30: read-idle cycles before a FIFO is soft-reset.
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 pkt_valid  input  1  source asserts while a packet byte is present.
REQ-005 data_in  input  2  header bits [1:0], destination address; 3 is invalid.
REQ-006 parity_done  input  1  register block has captured the parity byte.
REQ-007 low_pkt_valid  input  1  pkt_valid fell while the target FIFO was full.
REQ-008 full_0, full_1, full_2  input  1 each  per-FIFO full flags.
REQ-009 empty_0, empty_1, empty_2  input  1 each  per-FIFO empty flags.
REQ-010 read_enb_0, read_enb_1, read_enb_2  input  1 each  per-FIFO read strobes from the destinations.
REQ-011 write_enb  output  3  one-hot FIFO write enable.
REQ-012 fifo_full  output  1  full flag of the latched target FIFO.
REQ-013 vld_out_0, vld_out_1, vld_out_2  output  1 each  FIFO holds data.
REQ-014 soft_reset_0, soft_reset_1, soft_reset_2  output  1 each  single-cycle FIFO flush pulses.
REQ-015 detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy  output  1 each  state decodes.

Function
REQ-016 The FSM SHALL have states DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
REQ-017 DECODE_ADDRESS: pkt_valid, data_in<3, target empty -> LOAD_FIRST_DATA; target not empty -> WAIT_TILL_EMPTY; otherwise stay; data_in=3 SHALL leave the FSM in DECODE_ADDRESS.
REQ-018 When detect_add and pkt_valid and data_in<3, the address SHALL be latched into a 2-bit register on that edge and held until the next such edge.
REQ-019 WAIT_TILL_EMPTY -> LOAD_FIRST_DATA when the latched FIFO empty is 1; else stay.
REQ-020 LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
REQ-021 LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay; full has priority over !pkt_valid.
REQ-022 FIFO_FULL_STATE -> LOAD_AFTER_FULL when fifo_full=0; else stay.
REQ-023 LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
REQ-024 LOAD_PARITY -> CHECK_PARITY_ERROR; CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
REQ-025 A soft_reset pulse on the latched FIFO SHALL force DECODE_ADDRESS on the next edge from any state, overriding all other transitions.
REQ-026 Decodes SHALL be Moore, combinational from state: detect_add=DECODE_ADDRESS, lfd_state=LOAD_FIRST_DATA, ld_state=LOAD_DATA, laf_state=LOAD_AFTER_FULL, full_state=FIFO_FULL_STATE, rst_int_reg=CHECK_PARITY_ERROR.
REQ-027 busy SHALL be 1 in every state except DECODE_ADDRESS and LOAD_DATA.
REQ-028 write_enb SHALL be the one-hot of the latched address in LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL, else 3'b000.
REQ-029 fifo_full SHALL mux full_n by latched address; vld_out_n SHALL equal !empty_n, combinationally.
REQ-030 Per FIFO, an idle counter SHALL increment each cycle vld_out_n=1 and read_enb_n=0, and clear on read_enb_n=1 or empty_n=1.
REQ-031 When the counter reaches TIMEOUT-1 and still idle, soft_reset_n SHALL be 1 for exactly the next cycle and the counter SHALL clear; it SHALL NOT re-pulse before TIMEOUT further idle cycles.
REQ-032 Timers SHALL run independently of FSM state and of each other.

Reset
REQ-033 With resetn=0 at an edge: state=DECODE_ADDRESS, latched address=0, all counters=0, all soft_reset_n=0, write_enb=3'b000, busy=0, detect_add=1.
REQ-034 Reset mid-packet SHALL abandon the packet with no further write_enb assertion.

Structure
REQ-035 Package router_pkg SHALL hold the state enumeration, address width (2), invalid address constant (3) and default TIMEOUT.
REQ-036 The idle counter SHALL be a sub-module router_sft_timer, instantiated three times.

Verification
REQ-037 Header addr=1, FIFO1 empty, 4 payload then pkt_valid low -> states DA,LFD,LD x4,LP,CPE,DA; write_enb=3'b010 for 6 cycles.
REQ-038 Header addr=3 -> remains DECODE_ADDRESS, write_enb never nonzero, busy stays 0.
REQ-039 Header addr=2, empty_2=0 -> WAIT_TILL_EMPTY, busy=1; empty_2 rises -> LFD next edge.
REQ-040 full_0 asserted in LOAD_DATA -> FIFO_FULL_STATE, write_enb=0; deassert with low_pkt_valid=1 -> LAF then LP.
REQ-041 vld_out_0=1, no read for 30 cycles -> soft_reset_0 high exactly cycle 31, FSM (addr 0) to DA; read at cycle 29 -> no pulse.
REQ-042 resetn=0 during LOAD_DATA -> all outputs at REQ-033 values next edge.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router control block.
//   state_e        : controller FSM state encoding
//   AddrW          : width of the destination address field
//   AddrInvalid    : header address value that names no FIFO
//   TimeoutDefault : default read-idle cycles before a FIFO flush
//   addr_onehot    : one-hot FIFO select for an address (zero when invalid)
//   addr_mux       : picks the per-FIFO flag named by an address
package router_pkg;

  localparam int unsigned AddrW          = 2;
  localparam logic [AddrW-1:0] AddrInvalid = 2'd3;
  localparam int unsigned TimeoutDefault = 30;

  typedef enum logic [2:0] {
    StDecodeAddress,
    StLoadFirstData,
    StLoadData,
    StFifoFullState,
    StLoadAfterFull,
    StLoadParity,
    StCheckParityError,
    StWaitTillEmpty
  } state_e;

  function automatic logic [2:0] addr_onehot(input logic [AddrW-1:0] addr);
    logic [2:0] oh;
    oh = 3'b000;
    unique case (addr)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  function automatic logic addr_mux(input logic [2:0] flags, input logic [AddrW-1:0] addr);
    logic sel;
    sel = 1'b0;
    unique case (addr)
      2'd0:    sel = flags[0];
      2'd1:    sel = flags[1];
      2'd2:    sel = flags[2];
      default: sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/router_sft_timer.sv
// Per-FIFO read-idle timer. Counts cycles in which the FIFO holds data but the
// destination is not reading; after Timeout such cycles it emits a one-cycle
// soft_reset_o flush pulse and starts counting again from zero.
//   clock        : rising-edge clock
//   resetn       : synchronous active-low reset
//   empty_i      : FIFO empty flag (clears the count)
//   read_enb_i   : destination read strobe (clears the count)
//   soft_reset_o : registered single-cycle flush pulse
module router_sft_timer #(
  parameter int unsigned Timeout = 30
) (
  input  logic clock,
  input  logic resetn,
  input  logic empty_i,
  input  logic read_enb_i,
  output logic soft_reset_o
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Timeout - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (read_enb_i || empty_i) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      // Last idle cycle of the window: flush next cycle and restart the window.
      cnt_d   = '0;
      pulse_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign soft_reset_o = pulse_q;

endmodule

// File: rtl/router_ctrl.sv
// Router packet-flow controller. Decodes the header address, sequences the
// load of header/payload/parity bytes into one of three FIFOs, stalls on a
// full FIFO, and flushes FIFOs whose data is not read within TIMEOUT cycles.
//   clock, resetn                : clock and synchronous active-low reset
//   pkt_valid, data_in           : source byte strobe and header address bits
//   parity_done, low_pkt_valid   : status from the register block
//   full_n, empty_n, read_enb_n  : per-FIFO flags and destination read strobes
//   write_enb, fifo_full         : one-hot FIFO write select, full of target FIFO
//   vld_out_n, soft_reset_n      : FIFO has data, FIFO flush pulse
//   detect_add .. busy           : Moore state decodes
module router_ctrl
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  logic [2:0] full_v, empty_v, read_v, soft_v;

  assign full_v  = {full_2, full_1, full_0};
  assign empty_v = {empty_2, empty_1, empty_0};
  assign read_v  = {read_enb_2, read_enb_1, read_enb_0};

  assign vld_out_0 = !empty_0;
  assign vld_out_1 = !empty_1;
  assign vld_out_2 = !empty_2;

  assign soft_reset_0 = soft_v[0];
  assign soft_reset_1 = soft_v[1];
  assign soft_reset_2 = soft_v[2];

  router_sft_timer #(.Timeout(TIMEOUT)) u_timer_0 (
    .clock       (clock),
    .resetn      (resetn),
    .empty_i     (empty_0),
    .read_enb_i  (read_enb_0),
    .soft_reset_o(soft_v[0])
  );

  router_sft_timer #(.Timeout(TIMEOUT)) u_timer_1 (
    .clock       (clock),
    .resetn      (resetn),
    .empty_i     (empty_1),
    .read_enb_i  (read_enb_1),
    .soft_reset_o(soft_v[1])
  );

  router_sft_timer #(.Timeout(TIMEOUT)) u_timer_2 (
    .clock       (clock),
    .resetn      (resetn),
    .empty_i     (empty_2),
    .read_enb_i  (read_enb_2),
    .soft_reset_o(soft_v[2])
  );

  state_e           state_q, state_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic             addr_ok;
  logic             hdr_empty;

  assign addr_ok   = (data_in != AddrInvalid);
  // Header decisions use the incoming address; it is latched on the same edge.
  assign hdr_empty = addr_mux(empty_v, data_in);
  assign fifo_full = addr_mux(full_v, addr_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;

    if (state_q == StDecodeAddress && pkt_valid && addr_ok) begin
      addr_d = data_in;
    end

    unique case (state_q)
      StDecodeAddress: begin
        if (pkt_valid && addr_ok) begin
          state_d = hdr_empty ? StLoadFirstData : StWaitTillEmpty;
        end
      end
      StWaitTillEmpty: begin
        if (addr_mux(empty_v, addr_q)) state_d = StLoadFirstData;
      end
      StLoadFirstData: state_d = StLoadData;
      StLoadData: begin
        if (fifo_full)      state_d = StFifoFullState;
        else if (!pkt_valid) state_d = StLoadParity;
      end
      StFifoFullState: begin
        if (!fifo_full) state_d = StLoadAfterFull;
      end
      StLoadAfterFull: begin
        if (parity_done)        state_d = StDecodeAddress;
        else if (low_pkt_valid) state_d = StLoadParity;
        else                    state_d = StLoadData;
      end
      StLoadParity:       state_d = StCheckParityError;
      StCheckParityError: state_d = fifo_full ? StFifoFullState : StDecodeAddress;
      default:            state_d = StDecodeAddress;
    endcase

    // A flush of the FIFO being loaded abandons the packet from any state.
    if (addr_mux(soft_v, addr_q)) state_d = StDecodeAddress;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= StDecodeAddress;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    detect_add  = (state_q == StDecodeAddress);
    lfd_state   = (state_q == StLoadFirstData);
    ld_state    = (state_q == StLoadData);
    laf_state   = (state_q == StLoadAfterFull);
    full_state  = (state_q == StFifoFullState);
    rst_int_reg = (state_q == StCheckParityError);
    busy        = !(detect_add || ld_state);
    write_enb   = 3'b000;
    if (lfd_state || ld_state || laf_state || state_q == StLoadParity) begin
      write_enb = addr_onehot(addr_q);
    end
  end

endmodule

// File: tb/tb_router_ctrl.sv
// Directed self-checking bench for router_ctrl.
module tb_router_ctrl;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [1:0] data_in = 2'd0;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;
  logic       full_0 = 1'b0, full_1 = 1'b0, full_2 = 1'b0;
  logic       empty_0 = 1'b1, empty_1 = 1'b1, empty_2 = 1'b1;
  logic       read_enb_0 = 1'b0, read_enb_1 = 1'b0, read_enb_2 = 1'b0;

  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy;

  int errors = 0;
  int checks = 0;

  // Decode vector {detect_add, lfd, ld, laf, full_state, rst_int_reg, busy}
  localparam logic [6:0] DecDa  = 7'b100_0000;
  localparam logic [6:0] DecLfd = 7'b010_0001;
  localparam logic [6:0] DecLd  = 7'b001_0000;
  localparam logic [6:0] DecLaf = 7'b000_1001;
  localparam logic [6:0] DecFfs = 7'b000_0101;
  localparam logic [6:0] DecCpe = 7'b000_0011;
  localparam logic [6:0] DecLp  = 7'b000_0001;
  localparam logic [6:0] DecWte = 7'b000_0001;

  wire [6:0] dec = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy};
  wire [2:0] sr  = {soft_reset_2, soft_reset_1, soft_reset_0};
  wire [2:0] vld = {vld_out_2, vld_out_1, vld_out_0};

  router_ctrl #(.TIMEOUT(30)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .full_0       (full_0),
    .full_1       (full_1),
    .full_2       (full_2),
    .empty_0      (empty_0),
    .empty_1      (empty_1),
    .empty_2      (empty_2),
    .read_enb_0   (read_enb_0),
    .read_enb_1   (read_enb_1),
    .read_enb_2   (read_enb_2),
    .write_enb    (write_enb),
    .fifo_full    (fifo_full),
    .vld_out_0    (vld_out_0),
    .vld_out_1    (vld_out_1),
    .vld_out_2    (vld_out_2),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .rst_int_reg  (rst_int_reg),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick();
    tick();
    checks++;
    if (dec !== DecDa) begin
      errors++; $display("FAIL reset_decodes: got %b want %b", dec, DecDa);
    end
    checks++;
    if (write_enb !== 3'b000) begin
      errors++; $display("FAIL reset_write_enb: got %b want 000", write_enb);
    end
    checks++;
    if (sr !== 3'b000) begin
      errors++; $display("FAIL reset_soft_reset: got %b want 000", sr);
    end
    empty_1 = 1'b0;
    #1;
    checks++;
    if (vld !== 3'b010) begin
      errors++; $display("FAIL vld_out_comb: got %b want 010", vld);
    end
    empty_1 = 1'b1;
    resetn  = 1'b1;
    tick();
  endtask

  task automatic test_normal_packet;
    logic [6:0] exp_dec [8];
    logic [2:0] exp_wen [8];
    logic [7:0] pv;
    exp_dec = '{DecLfd, DecLd, DecLd, DecLd, DecLd, DecLp, DecCpe, DecDa};
    exp_wen = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
    pv      = 8'b0001_1111;
    data_in = 2'd1;
    for (int i = 0; i < 8; i++) begin
      pkt_valid = pv[i];
      tick();
      checks++;
      if (dec !== exp_dec[i]) begin
        errors++; $display("FAIL normal_state[%0d]: got %b want %b", i, dec, exp_dec[i]);
      end
      checks++;
      if (write_enb !== exp_wen[i]) begin
        errors++; $display("FAIL normal_wen[%0d]: got %b want %b", i, write_enb, exp_wen[i]);
      end
    end
  endtask

  task automatic test_invalid_addr;
    data_in   = 2'd3;
    pkt_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dec !== DecDa || write_enb !== 3'b000) begin
        errors++;
        $display("FAIL invalid_addr[%0d]: got dec=%b wen=%b want dec=%b wen=000",
                 i, dec, write_enb, DecDa);
      end
    end
    pkt_valid = 1'b0;
    tick();
  endtask

  task automatic test_wait_empty;
    data_in   = 2'd2;
    empty_2   = 1'b0;
    pkt_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (dec !== DecWte || write_enb !== 3'b000) begin
        errors++;
        $display("FAIL wait_empty[%0d]: got dec=%b wen=%b want dec=%b wen=000",
                 i, dec, write_enb, DecWte);
      end
    end
    empty_2 = 1'b1;
    tick();
    checks++;
    if (dec !== DecLfd || write_enb !== 3'b100) begin
      errors++;
      $display("FAIL wait_to_lfd: got dec=%b wen=%b want dec=%b wen=100", dec, write_enb, DecLfd);
    end
    pkt_valid = 1'b0;
    tick();  // LD
    tick();  // LP
    tick();  // CPE
    tick();
    checks++;
    if (dec !== DecDa) begin
      errors++; $display("FAIL wait_return_da: got %b want %b", dec, DecDa);
    end
  endtask

  task automatic test_fifo_full;
    logic [6:0] exp_dec [6];
    logic [2:0] exp_wen [6];
    data_in   = 2'd0;
    pkt_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (dec !== DecLd || write_enb !== 3'b001) begin
      errors++;
      $display("FAIL full_setup_ld: got dec=%b wen=%b want dec=%b wen=001", dec, write_enb, DecLd);
    end
    full_0 = 1'b1;
    #1;
    checks++;
    if (fifo_full !== 1'b1) begin
      errors++; $display("FAIL fifo_full_mux: got %b want 1", fifo_full);
    end
    exp_dec = '{DecFfs, DecFfs, DecLaf, DecLp, DecCpe, DecDa};
    exp_wen = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000};
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        full_0        = 1'b0;
        low_pkt_valid = 1'b1;
        pkt_valid     = 1'b0;
      end
      if (i == 4) low_pkt_valid = 1'b0;
      tick();
      checks++;
      if (dec !== exp_dec[i] || write_enb !== exp_wen[i]) begin
        errors++;
        $display("FAIL full_seq[%0d]: got dec=%b wen=%b want dec=%b wen=%b",
                 i, dec, write_enb, exp_dec[i], exp_wen[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    data_in   = 2'd1;
    pkt_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (write_enb !== 3'b010) begin
      errors++; $display("FAIL mid_setup_wen: got %b want 010", write_enb);
    end
    resetn = 1'b0;
    tick();
    checks++;
    if (dec !== DecDa || write_enb !== 3'b000 || sr !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_outputs: got dec=%b wen=%b sr=%b want dec=%b wen=000 sr=000",
               dec, write_enb, sr, DecDa);
    end
    // Latched address must be back to 0: full_1 must not reach fifo_full.
    full_1 = 1'b1;
    #1;
    checks++;
    if (fifo_full !== 1'b0) begin
      errors++; $display("FAIL mid_reset_addr: got fifo_full=%b want 0", fifo_full);
    end
    full_1 = 1'b0;
    tick();
    resetn    = 1'b1;
    pkt_valid = 1'b0;
    tick();
    checks++;
    if (dec !== DecDa || write_enb !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_abandon: got dec=%b wen=%b want dec=%b wen=000", dec, write_enb, DecDa);
    end
  endtask

  task automatic test_timeout;
    logic [2:0] exp_sr;
    resetn = 1'b0;
    tick();
    resetn    = 1'b1;
    data_in   = 2'd0;
    pkt_valid = 1'b1;
    tick();  // LFD
    tick();  // LD
    empty_0 = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      exp_sr = (e == 30) ? 3'b001 : 3'b000;
      checks++;
      if (sr !== exp_sr) begin
        errors++; $display("FAIL timeout_pulse[%0d]: got %b want %b", e, sr, exp_sr);
      end
    end
    tick();
    checks++;
    if (sr !== 3'b000 || dec !== DecDa) begin
      errors++;
      $display("FAIL timeout_flush: got sr=%b dec=%b want sr=000 dec=%b", sr, dec, DecDa);
    end
    pkt_valid = 1'b0;
    for (int e = 32; e <= 60; e++) begin
      tick();
      exp_sr = (e == 60) ? 3'b001 : 3'b000;
      checks++;
      if (sr !== exp_sr) begin
        errors++; $display("FAIL timeout_repulse[%0d]: got %b want %b", e, sr, exp_sr);
      end
    end
    empty_0 = 1'b1;
    tick();
  endtask

  task automatic test_read_clears_timer;
    resetn = 1'b0;
    tick();
    resetn  = 1'b1;
    empty_0 = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      read_enb_0 = (e == 29);
      tick();
      checks++;
      if (sr !== 3'b000) begin
        errors++; $display("FAIL read_no_pulse[%0d]: got %b want 000", e, sr);
      end
    end
    read_enb_0 = 1'b0;
    empty_0    = 1'b1;
  endtask

  initial begin
    test_reset();
    test_normal_packet();
    test_invalid_addr();
    test_wait_empty();
    test_fifo_full();
    test_reset_mid();
    test_timeout();
    test_read_clears_timer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
